// File: rtl/uart_pkg.sv
// Shared encodings and sizing helpers for the UART transmit scheduler.
// Used by uart_tx_sched and uart_tx_rr_arbiter (UART_TX_ROUND_ROBIN_EN selects arbitration).
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StWaiting = 2'b01,
    StSending = 2'b10
  } uart_state_e;

  // Start and stop bits wrapped around every data word.
  localparam int unsigned FrameOverhead = 2;

  function automatic int unsigned frame_bits(input int unsigned word_size);
    return word_size + FrameOverhead;
  endfunction

  function automatic int unsigned sc_width(input int unsigned oversample);
    return (oversample < 2) ? 1 : $clog2(oversample);
  endfunction

  function automatic int unsigned bc_width(input int unsigned word_size);
    return $clog2(frame_bits(word_size));
  endfunction

endpackage

// File: rtl/uart_tx_rr_arbiter.sv
// Two-requester grant logic for the UART transmit scheduler.
// UART_TX_ROUND_ROBIN_EN defined: ties alternate via a pointer; undefined: Req0 wins ties.
module uart_tx_rr_arbiter
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic update,
  output logic winner
);

`ifdef UART_TX_ROUND_ROBIN_EN
  // Pointer records the last requester granted; it resets to requester 1 so Req0 wins first.
  logic ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b1;
    end else if (update) begin
      ptr_q <= winner;
    end
  end

  always_comb begin
    winner = req1;
    if (req0 && req1) begin
      winner = ~ptr_q;
    end
  end
`else
  logic unused_ok;

  assign unused_ok = ^{clk, rst, update};

  always_comb begin
    winner = req1 & ~req0;
  end
`endif

endmodule

// File: rtl/uart_tx_sched.sv
// UART transmitter control unit: arbitrates two requesters and sequences the datapath.
// Define UART_TX_ROUND_ROBIN_EN for round-robin tie breaking; default is fixed priority.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned word_size      = 8,
  parameter int unsigned OVERSAMPLE     = 8,
  parameter int unsigned Num_state_bits = 2
) (
  input  logic Sample_clk,
  input  logic rst,
  input  logic Req0,
  input  logic Req1,
  output logic Ack0,
  output logic Ack1,
  output logic Sel,
  output logic load_XMT_datareg,
  output logic load_XMT_shftreg,
  output logic shift,
  output logic clear,
  output logic Busy,
  output logic Done
);

  localparam int unsigned ScW = sc_width(OVERSAMPLE);
  localparam int unsigned BcW = bc_width(word_size);
  localparam logic [ScW-1:0] ScLast = ScW'(OVERSAMPLE - 1);
  // Last bit time of the frame is the stop bit; it ends with clear, not shift.
  localparam logic [BcW-1:0] BcLast = BcW'(frame_bits(word_size) - 1);

  logic [Num_state_bits-1:0] state_q, state_d;
  logic [ScW-1:0]            sc_q, sc_d;
  logic [BcW-1:0]            bc_q, bc_d;
  logic                      sel_q, sel_d;
  logic                      winner;
  logic                      grant;

  uart_tx_rr_arbiter u_arbiter (
    .clk    (Sample_clk),
    .rst    (rst),
    .req0   (Req0),
    .req1   (Req1),
    .update (grant),
    .winner (winner)
  );

  always_ff @(posedge Sample_clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sc_q    <= '0;
      bc_q    <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      bc_q    <= bc_d;
      sel_q   <= sel_d;
    end
  end

  // During the grant cycle the datapath mux must follow Ack1, since Sel updates one cycle later.
  always_comb begin
    state_d          = state_q;
    sc_d             = sc_q;
    bc_d             = bc_q;
    sel_d            = sel_q;
    grant            = 1'b0;
    Ack0             = 1'b0;
    Ack1             = 1'b0;
    load_XMT_datareg = 1'b0;
    load_XMT_shftreg = 1'b0;
    shift            = 1'b0;
    clear            = 1'b0;
    Done             = 1'b0;
    Busy             = 1'b0;

    if (!rst) begin
      case (state_q)
        StIdle: begin
          if (Req0 || Req1) begin
            grant            = 1'b1;
            Ack0             = ~winner;
            Ack1             = winner;
            load_XMT_datareg = 1'b1;
            sel_d            = winner;
            state_d          = StWaiting;
          end
        end
        StWaiting: begin
          Busy             = 1'b1;
          load_XMT_shftreg = 1'b1;
          sc_d             = '0;
          bc_d             = '0;
          state_d          = StSending;
        end
        StSending: begin
          Busy = 1'b1;
          if (sc_q == ScLast) begin
            sc_d = '0;
            if (bc_q < BcLast) begin
              shift = 1'b1;
              bc_d  = bc_q + BcW'(1);
            end else begin
              clear   = 1'b1;
              Done    = 1'b1;
              bc_d    = '0;
              state_d = StIdle;
            end
          end else begin
            sc_d = sc_q + ScW'(1);
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  assign Sel = sel_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomised scoreboard bench for uart_tx_sched; honours UART_TX_ROUND_ROBIN_EN when defined.
module tb_uart_tx_sched;

  localparam int WS    = 8;
  localparam int OS    = 8;
  localparam int FRAME = 2 + (WS + 2) * OS;

`ifdef UART_TX_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 1'b0;
  logic req1 = 1'b0;
  logic ack0, ack1, sel, ldd, lds, shift, clear, busy, done;

  uart_tx_sched #(
    .word_size      (WS),
    .OVERSAMPLE     (OS),
    .Num_state_bits (2)
  ) dut (
    .Sample_clk       (clk),
    .rst              (rst),
    .Req0             (req0),
    .Req1             (req1),
    .Ack0             (ack0),
    .Ack1             (ack1),
    .Sel              (sel),
    .load_XMT_datareg (ldd),
    .load_XMT_shftreg (lds),
    .shift            (shift),
    .clear            (clear),
    .Busy             (busy),
    .Done             (done)
  );

  always #5 clk = ~clk;

  // Expected pulse vector: {Ack0, Ack1, load_data, load_shift, shift, clear, Done}
  typedef struct {
    int         cyc;
    logic [6:0] vec;
  } ev_t;

  ev_t  exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   free_at = 0;
  bit   ptr = 1'b1;
  bit   sel_exp = 1'b0;
  bit   sel_pend = 1'b0;
  bit   have_pend = 1'b0;
  bit   busy_exp = 1'b0;
  logic last_ack0 = 1'b0;
  logic last_ack1 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  function automatic logic [6:0] mk(input bit a0, input bit a1, input bit ld, input bit ls,
                                    input bit sh, input bit cl);
    return {a0, a1, ld, ls, sh, cl, cl};
  endfunction

  // Reference model: one frame is a fixed schedule of pulses relative to the grant cycle.
  always @(negedge clk) begin
    bit w;
    if (rst) begin
      exp_q.delete();
      free_at   = cyc;
      ptr       = 1'b1;
      sel_exp   = 1'b0;
      have_pend = 1'b0;
      busy_exp  = 1'b0;
    end else begin
      if (have_pend) begin
        sel_exp   = sel_pend;
        have_pend = 1'b0;
      end
      busy_exp = (cyc < free_at);
      if (cyc >= free_at && (req0 || req1)) begin
        if (req0 && req1) w = RR ? ~ptr : 1'b0;
        else w = req1;
        ptr       = w;
        sel_pend  = w;
        have_pend = 1'b1;
        exp_q.push_back('{cyc, mk(!w, w, 1'b1, 1'b0, 1'b0, 1'b0)});
        exp_q.push_back('{cyc + 1, mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)});
        for (int k = 1; k <= WS + 1; k++)
          exp_q.push_back('{cyc + 1 + k * OS, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)});
        exp_q.push_back('{cyc + 1 + (WS + 2) * OS, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)});
        free_at = cyc + FRAME;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT pulses or an event is due.
  always @(negedge clk) begin
    logic [6:0] v;
    #1;
    v = {ack0, ack1, ldd, lds, shift, clear, done};
    last_ack0 = ack0;
    last_ack1 = ack1;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      check("missed_event", 0, int'(exp_q[0].vec));
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      check("pulses", int'(v), int'(exp_q[0].vec));
      void'(exp_q.pop_front());
    end else if (v != 7'd0) begin
      check("stray_pulses", int'(v), 0);
    end
    check("busy", int'(busy), int'(busy_exp));
    check("sel", int'(sel), int'(sel_exp));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) step();
    // Both requesters held: exercises tie breaking across three frames.
    rst  = 1'b0;
    req0 = 1'b1;
    req1 = 1'b1;
    repeat (3 * FRAME + 5) step();
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (FRAME) step();

    // Mid-frame reset, then Req1 waits for a fresh frame.
    req0 = 1'b1;
    step();
    req0 = 1'b0;
    repeat (39) step();
    rst  = 1'b1;
    req1 = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    for (int i = 0; i < FRAME + 10; i++) begin
      step();
      if (last_ack1) req1 = 1'b0;
    end

    // Random traffic with withdrawals, late requests and two reset pulses.
    for (int i = 0; i < 6000; i++) begin
      step();
      if (i == 1500 || i == 4000) rst = 1'b1;
      else if (i == 1502 || i == 4002) rst = 1'b0;
      if (req0) begin
        if (last_ack0) req0 = ($urandom_range(3) == 0);
        else if ($urandom_range(31) == 0) req0 = 1'b0;
      end else begin
        req0 = ($urandom_range(7) == 0);
      end
      if (req1) begin
        if (last_ack1) req1 = ($urandom_range(3) == 0);
        else if ($urandom_range(31) == 0) req1 = 1'b0;
      end else begin
        req1 = ($urandom_range(7) == 0);
      end
    end

    rst  = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (FRAME + 5) step();
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
